// File: rtl/pulse_lvl_tx.sv
// Pulse-to-level request transmitter: counts pulse events and launches each one
// as a 4-phase level handshake toward an asynchronous destination domain.
//
// state    | meaning
// IDLE     | no handshake open; launch when events pending and ack_s low
// REQ      | lvl_sig high, waiting for ack_s to rise
// WAIT_LOW | lvl_sig low, waiting for ack_s to fall
module pulse_lvl_tx #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             ack_in,
  input  logic             clr_ovf,
  output logic             lvl_sig,
  output logic             busy,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  state_t           state_q, state_d;
  logic             ack_m_q, ack_m_d;
  logic             ack_s_q, ack_s_d;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             launch;
  logic             drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ack_m_q <= 1'b0;
      ack_s_q <= 1'b0;
      lvl_q   <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_m_q <= ack_m_d;
      ack_s_q <= ack_s_d;
      lvl_q   <= lvl_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // Launch only into a low ack so a stale ack from a previous handshake is never taken as a reply.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    ack_m_d = ack_in;
    ack_s_d = ack_m_q;
    case (state_q)
      IDLE: begin
        if ((pend_q != '0) && !ack_s_q) begin
          state_d = REQ;
          launch  = 1'b1;
        end
      end
      REQ: begin
        if (ack_s_q) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!ack_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    lvl_d = (state_d == REQ);
  end

  // A simultaneous new event and launch cancel out; saturation drops the event.
  always_comb begin
    pend_d = pend_q;
    drop   = 1'b0;
    if (pulse_in && !launch) begin
      if (pend_q == PEND_MAX) drop = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end else if (!pulse_in && launch) begin
      pend_d = pend_q - 1'b1;
    end
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  assign lvl_sig  = lvl_q;
  assign pend_cnt = pend_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q != IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_pulse_lvl_tx.sv
// Bench for pulse_lvl_tx: directed handshake scenarios plus randomized traffic,
// checked cycle by cycle against a behavioural model and an event-conservation count.
module tb_pulse_lvl_tx;
  localparam int CNT_W = 4;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pulse_in = 1'b0;
  logic             ack_in = 1'b0;
  logic             clr_ovf = 1'b0;
  logic             lvl_sig;
  logic             busy;
  logic [CNT_W-1:0] pend_cnt;
  logic             ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pulse_lvl_tx #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .ack_in   (ack_in),
    .clr_ovf  (clr_ovf),
    .lvl_sig  (lvl_sig),
    .busy     (busy),
    .pend_cnt (pend_cnt),
    .ovf      (ovf)
  );

  // model: phase 0 = no handshake, 1 = request raised, 2 = request dropped awaiting ack low
  int m_pend;
  int m_phase;
  bit m_ovf;
  bit m_s0, m_s1;
  bit lvl_h [8];
  bit loop_en = 1'b0;
  int loop_d  = 1;
  int rises = 0;
  bit prev_lvl = 1'b0;
  int n_pulses = 0;
  int n_drops  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_phase = 0; m_ovf = 0; m_s0 = 0; m_s1 = 0;
    for (int i = 0; i < 8; i++) lvl_h[i] = 0;
    prev_lvl = 0; rises = 0; n_pulses = 0; n_drops = 0;
  endtask

  task automatic cycle();
    bit s_old, launch, drop;
    @(posedge clk);
    s_old  = m_s1;
    launch = (m_phase == 0) && (m_pend > 0) && !s_old;
    case (m_phase)
      0:       if (launch) m_phase = 1;
      1:       if (s_old)  m_phase = 2;
      default: if (!s_old) m_phase = 0;
    endcase
    drop = 0;
    if (pulse_in && !launch) begin
      if (m_pend == MAX) drop = 1;
      else               m_pend++;
    end else if (!pulse_in && launch) begin
      m_pend--;
    end
    if (pulse_in) n_pulses++;
    if (drop)     n_drops++;
    if (drop)         m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    m_s1 = m_s0;
    m_s0 = ack_in;
    for (int i = 7; i > 0; i--) lvl_h[i] = lvl_h[i-1];
    lvl_h[0] = (m_phase == 1);
    #1;
    chk("lvl",  lvl_sig,  int'(m_phase == 1));
    chk("pend", pend_cnt, m_pend);
    chk("busy", busy,     int'(m_phase != 0 || m_pend != 0));
    chk("ovf",  ovf,      m_ovf);
    if (lvl_sig && !prev_lvl) rises++;
    prev_lvl = lvl_sig;
    if (loop_en) ack_in = lvl_h[loop_d];
  endtask

  task automatic drain(input int budget);
    int i;
    loop_en = 1;
    for (i = 0; i < budget; i++) begin
      cycle();
      if (m_phase == 0 && m_pend == 0 && !busy) break;
    end
    chk("drain_timeout", int'(i < budget), 1);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    int r0;
    int peak;
    model_reset();

    // reset held: outputs at reset values regardless of clock and inputs
    #1;
    chk("rst_lvl", lvl_sig, 0); chk("rst_busy", busy, 0);
    chk("rst_pend", pend_cnt, 0); chk("rst_ovf", ovf, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pulse_in = $urandom_range(0, 1);
      ack_in   = $urandom_range(0, 1);
    end
    chk("rsth_lvl", lvl_sig, 0); chk("rsth_busy", busy, 0);
    chk("rsth_pend", pend_cnt, 0); chk("rsth_ovf", ovf, 0);
    pulse_in = 0; ack_in = 0;
    @(posedge clk); #3 rst = 1;

    // single event, looped ack
    loop_en = 1; loop_d = 2; r0 = rises;
    pulse_in = 1; cycle();
    chk("lat_pend1", pend_cnt, 1); chk("lat_lvl0", lvl_sig, 0);
    pulse_in = 0; cycle();
    chk("lat_lvl1", lvl_sig, 1); chk("lat_pend0", pend_cnt, 0);
    drain(60);
    chk("single_rises", rises - r0, 1);

    // burst of five
    r0 = rises; peak = 0; loop_d = 1;
    for (int i = 0; i < 5; i++) begin
      pulse_in = 1; cycle();
      if (pend_cnt > peak) peak = pend_cnt;
    end
    pulse_in = 0;
    drain(200);
    chk("burst_peak", peak, 4);
    chk("burst_rises", rises - r0, 5);
    chk("burst_ovf", ovf, 0);

    // saturation with stuck request
    loop_en = 0; ack_in = 0;
    for (int i = 0; i < 20; i++) begin
      pulse_in = 1; cycle();
    end
    chk("sat_pend", pend_cnt, 15); chk("sat_ovf", ovf, 1); chk("sat_lvl", lvl_sig, 1);
    pulse_in = 0; clr_ovf = 1; cycle();
    chk("clr_ovf", ovf, 0);
    pulse_in = 1; clr_ovf = 1; cycle();
    chk("clr_vs_drop", ovf, 1); chk("clr_vs_drop_pend", pend_cnt, 15);
    pulse_in = 0; clr_ovf = 0;
    drain(400);
    chk("sat_conserve", rises, n_pulses - n_drops);

    // stale ack while idle
    loop_en = 0; ack_in = 1;
    repeat (3) cycle();
    pulse_in = 1; cycle();
    pulse_in = 0;
    repeat (3) begin
      cycle();
      chk("stale_hold", lvl_sig, 0);
    end
    chk("stale_pend", pend_cnt, 1);
    ack_in = 0;
    cycle(); chk("stale_a", lvl_sig, 0);
    cycle(); chk("stale_b", lvl_sig, 0);
    cycle(); chk("stale_rise", lvl_sig, 1);
    drain(60);

    // event on the launch edge
    r0 = rises;
    pulse_in = 1; cycle();
    chk("simul_pend_a", pend_cnt, 1);
    cycle();
    chk("simul_pend_b", pend_cnt, 1); chk("simul_lvl", lvl_sig, 1);
    pulse_in = 0;
    drain(80);
    chk("simul_rises", rises - r0, 2);

    // reset mid-handshake
    loop_en = 0; ack_in = 0;
    for (int i = 0; i < 4; i++) begin
      pulse_in = 1; cycle();
    end
    pulse_in = 0;
    chk("mid_pend", pend_cnt, 3); chk("mid_lvl", lvl_sig, 1);
    #2 rst = 0;
    #1;
    chk("arst_lvl", lvl_sig, 0); chk("arst_busy", busy, 0);
    chk("arst_pend", pend_cnt, 0); chk("arst_ovf", ovf, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1;
    repeat (6) begin
      cycle();
      chk("post_rst_lvl", lvl_sig, 0);
    end

    // randomized traffic
    for (int seg = 0; seg < 8; seg++) begin
      loop_en = ($urandom_range(0, 3) != 0);
      loop_d  = $urandom_range(0, 3);
      for (int i = 0; i < 80; i++) begin
        pulse_in = ($urandom_range(0, 2) == 0);
        clr_ovf  = ($urandom_range(0, 15) == 0);
        if (!loop_en) ack_in = $urandom_range(0, 1);
        cycle();
      end
    end
    pulse_in = 0; clr_ovf = 0;
    drain(600);
    chk("rand_conserve", rises, n_pulses - n_drops);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pulse_lvl_tx.md
PULSE_LVL_TX -- requirements
Module: pulse_lvl_tx

Interface
REQ-001 SHALL have parameter: CNT_W, 4, width of the pending-event counter; legal range 2..8.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: pulse_in  input  1  event request, synchronous to clk; each cycle sampled high = one event.
REQ-005 SHALL have port: ack_in  input  1  returned level from destination domain; asynchronous to clk.
REQ-006 SHALL have port: lvl_sig  output  1  registered request level sent to destination domain.
REQ-007 SHALL have port: clr_ovf  input  1  synchronous clear of ovf.
REQ-008 SHALL have port: busy  output  1  high while any event is pending or a handshake is in progress.
REQ-009 SHALL have port: pend_cnt  output  CNT_W  number of accepted events not yet launched.
REQ-010 SHALL have port: ovf  output  1  sticky flag; an event was dropped.

Function
REQ-011 SHALL pass ack_in through a two-flop synchronizer (ack_s); the FSM uses only ack_s.
REQ-012 SHALL implement a 4-phase handshake FSM with states IDLE, REQ, WAIT_LOW.
REQ-013 IDLE: lvl_sig=0; go to REQ when pend_cnt!=0 and ack_s==0; otherwise stay.
REQ-014 IDLE with pend_cnt!=0 and ack_s==1: SHALL stay in IDLE until ack_s==0 (no launch into a stale ack).
REQ-015 REQ: lvl_sig=1; go to WAIT_LOW when ack_s==1.
REQ-016 WAIT_LOW: lvl_sig=0; go to IDLE when ack_s==0.
REQ-017 lvl_sig SHALL be a flop output equal to (state==REQ); no combinational path from any input.
REQ-018 On the IDLE->REQ edge, pend_cnt SHALL decrement by 1.
REQ-019 pulse_in high SHALL increment pend_cnt at the same edge, unless saturated.
REQ-020 Increment and decrement at the same edge SHALL leave pend_cnt unchanged; no ovf.
REQ-021 pulse_in high with pend_cnt==2^CNT_W-1 and no decrement SHALL hold pend_cnt, drop the event, and set ovf.
REQ-022 ovf SHALL clear on clr_ovf; if a set and clr_ovf occur at the same edge, set wins.
REQ-023 busy SHALL be combinational: (state!=IDLE) or (pend_cnt!=0).
REQ-024 Latency: pulse_in high at edge E0 from idle with ack_s==0 -> pend_cnt=1 after E0; lvl_sig=1 and pend_cnt=0 after E1.
REQ-025 Back-to-back events SHALL each produce one full lvl_sig high/low cycle; lvl_sig low time is at least 1 cycle between requests.
REQ-026 The block SHALL never lose an event except per REQ-021.

Reset
REQ-027 On rst low, immediately: state=IDLE, lvl_sig=0, pend_cnt=0, ovf=0, both synchronizer flops=0, busy=0.
REQ-028 Reset mid-handshake SHALL abort the handshake and discard pending events; after release the FSM obeys REQ-014.
REQ-029 Outputs SHALL be held at reset values while rst is low regardless of clk, pulse_in or ack_in.

Verification
REQ-030 Single event: one pulse_in at E0, ack_in looped back from lvl_sig with 2-cycle delay -> lvl_sig rises after E1, exactly one high/low cycle, busy then 0, pend_cnt=0.
REQ-031 Burst: pulse_in high for 5 consecutive cycles, CNT_W=4, looped ack -> pend_cnt peaks at 4, exactly 5 lvl_sig rising edges, ovf=0.
REQ-032 Saturation: ack_in held 0 with lvl_sig stuck in REQ and 20 pulses -> pend_cnt holds 15, ovf=1; clr_ovf pulse -> ovf=0; clr_ovf coincident with a drop -> ovf stays 1.
REQ-033 Stale ack: ack_in=1 while IDLE with pend_cnt=1 -> lvl_sig stays 0 until ack_s==0, then rises next edge.
REQ-034 Reset mid-operation: assert rst while in REQ with pend_cnt=3 -> all outputs 0 asynchronously; after release with ack_in=0 and no pulses, lvl_sig remains 0.
REQ-035 Simultaneous: pulse_in high on the IDLE->REQ launch edge with pend_cnt=1 -> pend_cnt stays 1, second handshake follows.
